// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction memory block.
package imem_pkg;

    localparam int unsigned DEPTH_DEF  = 256;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] NOP = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/imem_sync_if.sv
// Load/fetch bus of imem_sync; IMEM_PARITY_EN adds the parity_err response line.
interface imem_sync_if
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              load_en;
    logic              load_we;
    logic [IDX_W-1:0]  load_addr;
    logic [DATA_W-1:0] load_wdata;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
    logic              busy;
`ifdef IMEM_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output load_en, load_we, load_addr, load_wdata,
        output fetch_req, fetch_pc, fetch_stall,
`ifdef IMEM_PARITY_EN
        input  parity_err,
`endif
        input  instr, instr_valid, fetch_fault, busy
    );

    modport slave (
        input  load_en, load_we, load_addr, load_wdata,
        input  fetch_req, fetch_pc, fetch_stall,
`ifdef IMEM_PARITY_EN
        output parity_err,
`endif
        output instr, instr_valid, fetch_fault, busy
    );

endinterface

// File: rtl/imem_array.sv
// Word storage: one write port, one synchronous read port with read enable.
module imem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Instruction memory with clear-on-reset, program load mode and registered fetch.
// Optional stored even parity per word when IMEM_PARITY_EN is defined.
module imem_sync
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    imem_sync_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             valid_q, fault_q, zero_q;

    logic             mem_we, mem_re;
    logic [IDX_W-1:0] mem_waddr, fetch_idx;
    logic [DATA_W-1:0] wr_word;
    logic [MEM_W-1:0] mem_wdata, mem_rdata;
    logic             fetch_bad, fetch_go, in_run;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN:  if (bus.load_en)  state_d = ST_LOAD;
            ST_LOAD: if (!bus.load_en) state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign in_run    = (state_q == ST_RUN);
    assign mem_we    = !rst && ((state_q == ST_CLEAR) || (state_q == ST_LOAD && bus.load_we));
    assign mem_waddr = (state_q == ST_CLEAR) ? clr_idx_q : bus.load_addr;
    assign wr_word   = (state_q == ST_CLEAR) ? DATA_W'(NOP) : bus.load_wdata;
`ifdef IMEM_PARITY_EN
    assign mem_wdata = {^wr_word, wr_word};
`else
    assign mem_wdata = wr_word;
`endif

    // Any PC bit above the index field means out of range; never wrap.
    assign fetch_bad = (bus.fetch_pc[1:0] != 2'b00) ||
                       ((bus.fetch_pc >> (IDX_W + 2)) != '0);
    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign fetch_go  = in_run && bus.fetch_req && !bus.fetch_stall;
    assign mem_re    = fetch_go && !fetch_bad;

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (mem_re),
        .raddr_i (fetch_idx),
        .rdata_o (mem_rdata)
    );

    // zero_q makes instr read as NOP after reset or a faulting fetch, and holds across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (!in_run) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!bus.fetch_stall) begin
            valid_q <= bus.fetch_req;
            fault_q <= bus.fetch_req && fetch_bad;
            if (bus.fetch_req) zero_q <= fetch_bad;
        end
    end

    assign bus.instr       = zero_q ? DATA_W'(NOP) : mem_rdata[DATA_W-1:0];
    assign bus.instr_valid = valid_q && in_run;
    assign bus.fetch_fault = fault_q && in_run;
    assign bus.busy        = !in_run;
`ifdef IMEM_PARITY_EN
    assign bus.parity_err  = bus.instr_valid && !bus.fetch_fault && (^mem_rdata);
`endif

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: behavioural model plus directed and random stimulus.
module tb_imem_sync;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_sync_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_sync #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode flags, a word array and the last response.
    logic [31:0] m_mem [DEPTH];
    bit          m_flip [DEPTH];
    int          m_clr_cnt;
    bit          m_clearing, m_loading;
    logic [31:0] m_instr;
    bit          m_valid, m_fault, m_perr;

    always @(posedge clk) begin
        if (rst) begin
            m_clearing = 1'b1;
            m_loading  = 1'b0;
            m_clr_cnt  = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = 32'h0;
                m_flip[i] = 1'b0;
            end
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_perr  = 1'b0;
        end else if (m_clearing) begin
            m_clr_cnt++;
            if (m_clr_cnt == DEPTH) m_clearing = 1'b0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_perr  = 1'b0;
        end else if (m_loading) begin
            if (bus.load_we) begin
                m_mem[bus.load_addr]  = bus.load_wdata;
                m_flip[bus.load_addr] = 1'b0;
            end
            if (!bus.load_en) m_loading = 1'b0;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_perr  = 1'b0;
        end else begin
            if (!bus.fetch_stall) begin
                if (bus.fetch_req) begin
                    m_valid = 1'b1;
                    if (bus.fetch_pc % 4 != 0 || bus.fetch_pc >= 32'(DEPTH * 4)) begin
                        m_fault = 1'b1;
                        m_instr = 32'h0;
                        m_perr  = 1'b0;
                    end else begin
                        m_fault = 1'b0;
                        m_instr = m_mem[bus.fetch_pc / 4];
                        m_perr  = m_flip[bus.fetch_pc / 4];
                    end
                end else begin
                    m_valid = 1'b0;
                    m_fault = 1'b0;
                    m_perr  = 1'b0;
                end
            end
            if (bus.load_en) m_loading = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(bus.busy), 64'(m_clearing || m_loading));
            check("instr", 64'(bus.instr), 64'(m_instr));
            check("instr_valid", 64'(bus.instr_valid), 64'(!(m_clearing || m_loading) && m_valid));
            check("fetch_fault", 64'(bus.fetch_fault), 64'(!(m_clearing || m_loading) && m_fault));
`ifdef IMEM_PARITY_EN
            check("parity_err", 64'(bus.parity_err), 64'(!(m_clearing || m_loading) && m_valid && m_perr));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_not_busy(input string name);
        int cnt;
        cnt = 0;
        while (bus.busy && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (bus.busy) check(name, 64'(bus.busy), 64'd0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        step();
    endtask

    initial begin
        int busy_cnt;
        int r;
        bus.load_en     = 1'b0;
        bus.load_we     = 1'b0;
        bus.load_addr   = '0;
        bus.load_wdata  = '0;
        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_stall = 1'b0;

        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        step();
        check("rst_busy", 64'(bus.busy), 64'd1);
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_instr", 64'(bus.instr), 64'd0);

        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!bus.busy) break;
            busy_cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'd256);

        fetch(32'h40);
        check("clr_instr", 64'(bus.instr), 64'd0);
        check("clr_valid", 64'(bus.instr_valid), 64'd1);
        check("clr_fault", 64'(bus.fetch_fault), 64'd0);
        bus.fetch_req = 1'b0;

        bus.load_en = 1'b1;
        step();
        check("load_busy", 64'(bus.busy), 64'd1);
        bus.load_we = 1'b1;
        bus.load_addr = 8'd3; bus.load_wdata = 32'h2024000A; step();
        bus.load_addr = 8'd4; bus.load_wdata = 32'h0BAD0004; step();
        bus.load_addr = 8'd1; bus.load_wdata = 32'h13572468;
        bus.load_en = 1'b0;
        step();
        bus.load_we = 1'b0;

        fetch(32'h04);
        check("last_load_word", 64'(bus.instr), 64'h13572468);
        fetch(32'h0C);
        check("word3", 64'(bus.instr), 64'h2024000A);
        fetch(32'h06);
        check("mis_fault", 64'(bus.fetch_fault), 64'd1);
        check("mis_instr", 64'(bus.instr), 64'd0);
        fetch(32'h400);
        check("oor_fault", 64'(bus.fetch_fault), 64'd1);
        fetch(32'h3FC);
        check("last_fault", 64'(bus.fetch_fault), 64'd0);
        check("last_valid", 64'(bus.instr_valid), 64'd1);

        fetch(32'h0C);
        bus.fetch_stall = 1'b1;
        bus.fetch_pc    = 32'h10;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", 64'(bus.instr), 64'h2024000A);
        end
        bus.fetch_stall = 1'b0;
        bus.fetch_req   = 1'b0;
        step();
        check("idle_valid", 64'(bus.instr_valid), 64'd0);
        check("idle_hold", 64'(bus.instr), 64'h2024000A);

        for (int i = 0; i < 600; i++) begin
            bus.fetch_req   = 1'($urandom % 2);
            bus.fetch_stall = ($urandom % 4 == 0);
            r = int'($urandom % 8);
            if (r < 6)       bus.fetch_pc = ($urandom % DEPTH) * 4;
            else if (r == 6) bus.fetch_pc = $urandom;
            else             bus.fetch_pc = ($urandom % 2 == 0) ? 32'(DEPTH * 4 - 4) : 32'(DEPTH * 4);
            if ($urandom % 30 == 0) bus.load_en = !bus.load_en;
            bus.load_we    = 1'($urandom % 2);
            bus.load_addr  = 8'($urandom % DEPTH);
            bus.load_wdata = $urandom;
            step();
        end
        bus.load_en = 1'b0;
        bus.load_we = 1'b0;
        bus.fetch_stall = 1'b0;
        step();
        step();

`ifdef IMEM_PARITY_EN
        bus.load_en = 1'b1; step();
        bus.load_we = 1'b1;
        bus.load_addr = 8'd2; bus.load_wdata = 32'h0000_0007; step();
        bus.load_addr = 8'd3; bus.load_wdata = 32'h2024000A; step();
        bus.load_we = 1'b0; bus.load_en = 1'b0; step();
        dut.u_array.mem_q[2][DATA_W] = ~dut.u_array.mem_q[2][DATA_W];
        m_flip[2] = 1'b1;
        fetch(32'h08);
        check("perr_set", 64'(bus.parity_err), 64'd1);
        fetch(32'h0C);
        check("perr_clr", 64'(bus.parity_err), 64'd0);
`endif

        bus.fetch_req = 1'b0;
        bus.load_en = 1'b1;
        step();
        bus.load_we = 1'b1; bus.load_addr = 8'd1; bus.load_wdata = 32'hFFFFFFFF;
        step();
        bus.load_we = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        bus.load_en = 1'b0;
        step();
        check("rst_in_load_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        wait_not_busy("clear_timeout");
        fetch(32'h04);
        check("reload_discard", 64'(bus.instr), 64'd0);
        check("reload_valid", 64'(bus.instr_valid), 64'd1);
        bus.fetch_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 Parameter DEPTH, default 256, SHALL be the instruction word count, a power of two, minimum 4.
REQ-002 Parameter DATA_W, default 32, SHALL be the instruction word width in bits.
REQ-003 Parameter ADDR_W, default 32, SHALL be the byte-address (PC) width.
REQ-004 Derived IDX_W = log2(DEPTH) SHALL be the word-index width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 load_en  in  1  SHALL request LOAD mode (program download).
REQ-008 load_we  in  1  SHALL be the word write strobe, honoured only in LOAD.
REQ-009 load_addr  in  IDX_W  SHALL be the word index for the write.
REQ-010 load_wdata  in  DATA_W  SHALL be the write data.
REQ-011 fetch_req  in  1  SHALL be the fetch request.
REQ-012 fetch_pc  in  ADDR_W  SHALL be the byte address of the fetch.
REQ-013 fetch_stall  in  1  SHALL freeze the fetch response registers.
REQ-014 instr  out  DATA_W  SHALL be the registered fetched instruction.
REQ-015 instr_valid  out  1  SHALL qualify instr.
REQ-016 fetch_fault  out  1  SHALL flag a misaligned or out-of-range fetch, aligned with instr_valid.
REQ-017 busy  out  1  SHALL be high in CLEAR and LOAD states.

Function
REQ-018 FSM states SHALL be CLEAR, RUN, LOAD.
REQ-019 CLEAR SHALL write NOP (all zeros) to one word per cycle, index counter 0 to DEPTH-1, then enter RUN.
REQ-020 RUN SHALL enter LOAD on the cycle after load_en is sampled high; LOAD SHALL return to RUN on the cycle after load_en is sampled low.
REQ-021 In LOAD, load_we high SHALL write load_wdata to word load_addr at that edge; load_we outside LOAD SHALL be ignored.
REQ-022 In RUN, fetch_req high with fetch_stall low at edge N SHALL drive instr/instr_valid/fetch_fault valid from edge N (one-cycle latency).
REQ-023 Word index SHALL be fetch_pc[IDX_W+1:2].
REQ-024 fetch_pc[1:0] nonzero, or any fetch_pc bit above IDX_W+1 set, SHALL give fetch_fault=1, instr=NOP, instr_valid=1.
REQ-025 fetch_req low with fetch_stall low SHALL clear instr_valid and fetch_fault next edge; instr holds last value.
REQ-026 fetch_stall high SHALL hold instr, instr_valid, fetch_fault unchanged and ignore fetch_req.
REQ-027 fetch_req in CLEAR or LOAD SHALL be ignored; instr_valid and fetch_fault SHALL be 0 in those states.
REQ-028 A write in the final LOAD cycle SHALL be visible to the first RUN fetch.
REQ-029 Fetching the last word (index DEPTH-1) SHALL not fault; index wrap SHALL never occur silently.

Reset
REQ-030 rst SHALL force state CLEAR, counter 0, instr=0, instr_valid=0, fetch_fault=0, busy=1, parity_err=0.
REQ-031 rst asserted mid-CLEAR or mid-LOAD SHALL restart CLEAR from index 0, discarding loaded contents.

Configuration
REQ-032 Macro IMEM_PARITY_EN defined SHALL add one even-parity bit per word (computed on every write), output port parity_err (1 bit), set with instr_valid when the fetched word's stored parity mismatches, and cleared when instr_valid clears.
REQ-033 Without IMEM_PARITY_EN, no parity storage and no parity_err port SHALL exist; all other behaviour identical.

Structure
REQ-034 Package imem_pkg SHALL hold the FSM state enum, the NOP constant, and default DEPTH/DATA_W/ADDR_W constants.
REQ-035 Storage SHALL be a sub-module imem_array (one write port, one synchronous read port, width DATA_W plus optional parity bit); FSM, fault and response logic stay in imem_sync.

Verification
REQ-036 Reset, DEPTH=256 -> busy high exactly 256 cycles, then fetch pc=0x40 returns instr=0, instr_valid=1, fault=0.
REQ-037 LOAD writes index 3 = 0x2024000A, exit LOAD, fetch pc=0x0C -> instr=0x2024000A one cycle later.
REQ-038 Fetch pc=0x06 -> fault=1, instr=0; fetch pc=0x400 (DEPTH=256) -> fault=1; pc=0x3FC -> fault=0.
REQ-039 Fetch pc=0x0C then stall 3 cycles while fetch_pc=0x10 -> instr stays at word 3 value for all 3 cycles.
REQ-040 rst asserted 5 cycles into LOAD after writing 0xFFFFFFFF to index 1 -> after CLEAR, fetch pc=0x04 returns 0.
REQ-041 IMEM_PARITY_EN: force-flip stored parity of index 2, fetch pc=0x08 -> parity_err=1 with instr_valid; next fetch of index 3 -> parity_err=0.
